// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous-read DMEM between the core's
// stage-2 load/store port and an external host/NIC requester.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   core_mem_en/store_en/addr/wdata core request; core_stall = denied
//   core_rdata                     load return (passthrough of dmem_rdata)
//   host_req/we/addr/wdata         host request, held until host_gnt
//   host_gnt, host_rvalid, host_rdata  host accept / read return
//   dmem_en/we/addr/wdata, dmem_rdata  DMEM port (read data 1 cycle late)
module dmem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  core_mem_en,
   input  logic                  core_store_en,
   input  logic [ADDR_WIDTH-1:0] core_addr,
   input  logic [DATA_WIDTH-1:0] core_wdata,
   output logic                  core_stall,
   output logic [DATA_WIDTH-1:0] core_rdata,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic                  host_gnt,
   output logic                  host_rvalid,
   output logic [DATA_WIDTH-1:0] host_rdata,
   output logic                  dmem_en,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   input  logic [DATA_WIDTH-1:0] dmem_rdata
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] LP_MAX = WW'(MAX_WAIT);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CORE = 2'd1;
   localparam logic [1:0] OWN_HOST = 2'd2;

   logic [WW-1:0] r_wait_cnt;
   logic [1:0]    r_owner;

   logic          w_force;
   logic          w_core_win;
   logic          w_host_win;
   logic [1:0]    w_owner_nxt;
   logic [WW-1:0] w_wait_nxt;

   // Host is forced through only when it has been starved MAX_WAIT
   // consecutive cycles; the counter clearing on that grant guarantees
   // the core wins the next conflict.
   assign w_force    = host_req && (r_wait_cnt == LP_MAX);
   assign w_core_win = !rst && core_mem_en && !w_force;
   assign w_host_win = !rst && host_req && (!core_mem_en || w_force);

   assign host_gnt   = w_host_win;
   assign core_stall = !rst && core_mem_en && w_force;

   always_comb begin
      dmem_en    = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      unique case (1'b1)
         w_core_win: begin
            dmem_en    = 1'b1;
            dmem_we    = core_store_en;
            dmem_addr  = core_addr;
            dmem_wdata = core_wdata;
         end
         w_host_win: begin
            dmem_en    = 1'b1;
            dmem_we    = host_we;
            dmem_addr  = host_addr;
            dmem_wdata = host_wdata;
         end
         default: begin
            dmem_en    = 1'b0;
         end
      endcase
   end

   always_comb begin
      w_wait_nxt = '0;
      if (host_req && !w_host_win) begin
         if (r_wait_cnt == LP_MAX)
            w_wait_nxt = LP_MAX;
         else
            w_wait_nxt = r_wait_cnt + 1'b1;
      end
   end

   always_comb begin
      w_owner_nxt = OWN_NONE;
      unique case (1'b1)
         (w_host_win && !host_we):      w_owner_nxt = OWN_HOST;
         (w_core_win && !core_store_en): w_owner_nxt = OWN_CORE;
         default:                        w_owner_nxt = OWN_NONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt <= '0;
         r_owner    <= OWN_NONE;
      end else begin
         r_wait_cnt <= w_wait_nxt;
         r_owner    <= w_owner_nxt;
      end
   end

   // Gated by rst so a read granted just before reset never returns.
   assign host_rvalid = !rst && (r_owner == OWN_HOST);
   assign core_rdata  = dmem_rdata;
   assign host_rdata  = dmem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter
// with a small behavioural synchronous-read DMEM.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_mem_en, core_store_en;
   logic [31:0] core_addr;
   logic [63:0] core_wdata;
   logic        core_stall;
   logic [63:0] core_rdata;
   logic        host_req, host_we;
   logic [31:0] host_addr;
   logic [63:0] host_wdata;
   logic        host_gnt, host_rvalid;
   logic [63:0] host_rdata;
   logic        dmem_en, dmem_we;
   logic [31:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [63:0] dmem_rdata;

   logic [63:0] mem [0:255];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dmem_en) begin
         if (dmem_we) mem[dmem_addr[7:0]] <= dmem_wdata;
         else         dmem_rdata <= mem[dmem_addr[7:0]];
      end
   end

   dmem_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(64), .MAX_WAIT(4)
   ) dut (
      .clk(clk), .rst(rst),
      .core_mem_en(core_mem_en), .core_store_en(core_store_en),
      .core_addr(core_addr), .core_wdata(core_wdata),
      .core_stall(core_stall), .core_rdata(core_rdata),
      .host_req(host_req), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid),
      .host_rdata(host_rdata),
      .dmem_en(dmem_en), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle();
      core_mem_en = 0; core_store_en = 0;
      core_addr = '0; core_wdata = '0;
      host_req = 0; host_we = 0;
      host_addr = '0; host_wdata = '0;
   endtask

   task automatic core_set(input logic st, input logic [31:0] a,
                           input logic [63:0] d);
      core_mem_en = 1; core_store_en = st;
      core_addr = a; core_wdata = d;
   endtask

   task automatic host_set(input logic we, input logic [31:0] a,
                           input logic [63:0] d);
      host_req = 1; host_we = we;
      host_addr = a; host_wdata = d;
   endtask

   // Drive at negedge; combinational outputs settle and are sampled at +1.
   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      idle();
      rst = 1;
      // Reset with both requesting: everything quiet.
      core_set(1, 32'h30, 64'h99);
      host_set(0, 32'h20, 64'h0);
      repeat (2) begin
         cyc(); #1;
         chk("rst_dmem_en", dmem_en, 0);
         chk("rst_dmem_we", dmem_we, 0);
         chk("rst_host_gnt", host_gnt, 0);
         chk("rst_core_stall", core_stall, 0);
         chk("rst_host_rvalid", host_rvalid, 0);
      end

      // Continuous contention right out of reset (wait_cnt from 0).
      core_set(0, 32'h30, 64'h0);
      for (int c = 0; c < 6; c++) begin
         cyc();
         rst = 0;
         if (c == 5) host_req = 0;
         #1;
         if (c < 5) begin
            chk("cont_gnt", host_gnt, (c == 4));
            chk("cont_stall", core_stall, (c == 4));
            chk("cont_addr", dmem_addr, (c == 4) ? 64'h20 : 64'h30);
         end else begin
            chk("cont_c5_stall", core_stall, 0);
            chk("cont_c5_addr", dmem_addr, 64'h30);
         end
         if (c >= 1) chk("cont_rvalid", host_rvalid, (c == 5));
      end

      // Host-only write then read of 0x10.
      cyc(); idle(); host_set(1, 32'h10, 64'hDEADBEEF); #1;
      chk("hw_gnt", host_gnt, 1);
      chk("hw_we", dmem_we, 1);
      cyc(); idle(); #1;
      chk("hw_rvalid", host_rvalid, 0);
      chk("idle_en", dmem_en, 0);
      chk("idle_addr", dmem_addr, 0);
      chk("idle_wdata", dmem_wdata, 0);
      cyc(); host_set(0, 32'h10, 64'h0); #1;
      chk("hr_gnt", host_gnt, 1);
      chk("hr_addr", dmem_addr, 64'h10);
      chk("hr_we", dmem_we, 0);
      cyc(); idle(); #1;
      chk("hr_rvalid", host_rvalid, 1);
      chk("hr_rdata", host_rdata, 64'hDEADBEEF);
      cyc(); #1;
      chk("hr_rvalid_end", host_rvalid, 0);

      // Core store 0x55 @0x8, then host read of 0x8 under contention.
      cyc(); core_set(1, 32'h8, 64'h55); #1;
      chk("cs_stall", core_stall, 0);
      chk("cs_wdata", dmem_wdata, 64'h55);
      for (int c = 0; c < 6; c++) begin
         cyc();
         idle();
         if (c < 5) begin
            core_set(0, 32'h30, 64'h0);
            host_set(0, 32'h8, 64'h0);
         end
         #1;
         if (c < 5) chk("alt_gnt", host_gnt, (c == 4));
         if (c < 5) chk("alt_rvalid", host_rvalid, 0);
         else begin
            chk("alt_rvalid5", host_rvalid, 1);
            chk("alt_rdata", host_rdata, 64'h55);
         end
      end

      // Same-address write conflict: core wins first, host lands last.
      cyc(); core_set(1, 32'h40, 64'h11); host_set(1, 32'h40, 64'h22); #1;
      chk("wc_gnt0", host_gnt, 0);
      chk("wc_wdata0", dmem_wdata, 64'h11);
      for (int c = 1; c < 5; c++) begin
         cyc(); core_set(0, 32'h48, 64'h0); #1;
         if (c == 1) chk("wc_mem_core", mem[8'h40], 64'h11);
         chk("wc_gnt", host_gnt, (c == 4));
         chk("wc_stall", core_stall, (c == 4));
      end
      chk("wc_wdata4", dmem_wdata, 64'h22);
      cyc(); idle(); host_set(0, 32'h40, 64'h0); #1;
      chk("wc_rd_gnt", host_gnt, 1);
      cyc(); idle(); #1;
      chk("wc_final", host_rdata, 64'h22);

      // Reset the cycle after a granted host read: no rvalid.
      cyc(); host_set(0, 32'h10, 64'h0); #1;
      chk("rr_gnt", host_gnt, 1);
      cyc(); rst = 1; #1;
      chk("rr_rvalid1", host_rvalid, 0);
      chk("rr_rst_gnt", host_gnt, 0);
      cyc(); rst = 0; idle(); #1;
      chk("rr_rvalid2", host_rvalid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
